if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage: PC register, next-PC select, instruction-memory request FSM and IF/ID pipeline register.
//  Directly upstream of the ID stage and of the hazard detection unit.
//  Consumes that unit's PCWrite/IF_IDWrite/IF_Flush and the EX-stage redirect (EX_JumpOP + targets).
//  Tolerates variable-latency instruction memory.
// PARAMETERS
//  bit_size  32      datapath / address width
//  RESET_PC  32'h0   PC value after reset
//  PC_STEP   4       sequential PC increment (bytes)
// PORTS
//  clk            in   1         single clock, all state on rising edge
//  rst            in   1         asynchronous, active-low reset
//  PCWrite        in   1         0 = freeze PC (load-use stall)
//  IF_IDWrite     in   1         0 = hold IF/ID register contents
//  IF_Flush       in   1         1 = load bubble into IF/ID
//  EX_JumpOP      in   2         00 none, 01 branch taken, 10 jump imm, 11 jump reg
//  EX_BranchAddr  in   bit_size  target for 01
//  EX_JumpAddr    in   bit_size  target for 10
//  EX_RegAddr     in   bit_size  target for 11
//  IM_Req         out  1         instruction-memory request
//  IM_Addr        out  bit_size  fetch address; stable while IM_Req=1 and no IM_Valid
//  IM_Valid       in   1         response strobe; 1 cycle, at least 1 cycle after request
//  IM_Data        in   bit_size  instruction, valid with IM_Valid
//  ID_Instr       out  bit_size  IF/ID instruction (NOP 32'h0 on bubble)
//  ID_PC          out  bit_size  IF/ID PC of ID_Instr
//  ID_Valid       out  1         IF/ID holds a real instruction
//  Fetch_Stall    out  1         IF/ID wanted an instruction but none was available
// BEHAVIOUR
//  Reset values:
//   - PC=RESET_PC, state=FETCH, IM_Req=1, IM_Addr=RESET_PC.
//   - ID_Instr=0, ID_PC=0, ID_Valid=0, Fetch_Stall=0.
//  States:
//   - FETCH: IM_Req=1, IM_Addr=PC, awaiting IM_Valid.
//   - HOLD: instruction latched in hold reg, awaiting IF/ID acceptance; IM_Req=0.
//   - DROP: a stale request is outstanding; IM_Req=0, discard the next IM_Valid, then go to FETCH.
//  avail = (state==HOLD) | (state==FETCH & IM_Valid); instruction = hold reg or IM_Data respectively.
//  accept = IF_IDWrite & PCWrite & ~IF_Flush & avail & (EX_JumpOP==0).
//  IF/ID register:
//   - IF_IDWrite=0: hold.
//   - else IF_Flush=1 or ~avail: bubble (ID_Instr=0, ID_Valid=0).
//   - else load instruction, ID_PC=PC, ID_Valid=1.
//  Fetch_Stall (registered) = IF_IDWrite & ~IF_Flush & ~avail.
//  PC update, in priority order:
//   1. EX_JumpOP!=0: PC<=target selected by EX_JumpOP. Redirect wins over PCWrite=0.
//      Next state is DROP if in FETCH without IM_Valid this cycle, otherwise FETCH.
//   2. accept: PC<=PC+PC_STEP (mod 2^bit_size, wraps silently); next state FETCH.
//   3. otherwise PC holds. FETCH+IM_Valid without accept -> HOLD; HOLD stays HOLD.
//  Latency:
//   - Zero-wait memory (IM_Valid the cycle after request): one instruction per cycle.
//   - Redirect: the first target instruction reaches IF/ID 2 cycles after EX_JumpOP later drops, plus memory wait.
//  Boundary cases:
//   - IF_Flush with IF_IDWrite=0: hold wins.
//   - IM_Valid in DROP: ignored; never reaches IF/ID.
//   - rst mid-request: any in-flight response after reset release is treated as fresh. Memory must drop requests on reset.
// CONFIGURATION
//  IF_PERF_EN defined:
//   - Adds out ports Perf_Fetch[31:0] (accept count) and Perf_Stall[31:0] (Fetch_Stall cycles).
//   - Both reset to 0 and saturate at 32'hFFFF_FFFF.
//  IF_PERF_EN undefined: the ports and counters are absent; behaviour otherwise identical.
// STRUCTURE
//  Package if_pkg:
//   - JumpOP encodings (JOP_NONE/BR/J/JR).
//   - NOP_INSTR.
//   - FSM state encoding (FETCH/HOLD/DROP).
//  Sub-module if_id_reg: IF/ID register with hold/bubble/load, instantiated once. FSM and PC stay in if_stage.
// TESTING
//  1. rst=0 then release, IM_Valid every cycle after request, data=PC -> ID_PC 0,4,8,... back-to-back, ID_Valid=1.
//  2. IM_Valid 3 cycles after each request -> Fetch_Stall=1 for 2 cycles per instr, bubbles, IM_Addr stable.
//  3. PCWrite=IF_IDWrite=0 for 2 cycles at PC=0x10 -> ID holds 0x0C instr, state HOLD, then 0x10 loads.
//  4. EX_JumpOP=11, EX_RegAddr=0x400, IF_Flush=1 while request pending -> IF/ID bubble, stale response dropped, next ID_PC=0x400.
//  5. PC=0xFFFF_FFFC sequential accept -> next IM_Addr=0x0.
//  6. IF_PERF_EN: 10 accepts, 4 stall cycles -> Perf_Fetch=10, Perf_Stall=4; rst mid-run clears both.

Source files
------------

// File: rtl/if_pkg.sv
// Shared encodings for the instruction-fetch stage: redirect opcodes, bubble
// instruction and fetch FSM states.
`default_nettype none

package if_pkg;

   localparam logic [1:0] JOP_NONE = 2'b00;
   localparam logic [1:0] JOP_BR   = 2'b01;
   localparam logic [1:0] JOP_J    = 2'b10;
   localparam logic [1:0] JOP_JR   = 2'b11;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_HOLD  = 2'd1;
   localparam logic [1:0] ST_DROP  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold, bubble and load.
`default_nettype none

module if_id_reg
   import if_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         write_en,
   input  logic         bubble,
   input  logic [W-1:0] instr_in,
   input  logic [W-1:0] pc_in,
   output logic [W-1:0] instr,
   output logic [W-1:0] pc,
   output logic         valid
);

   // A bubble clears the instruction and valid bit; the PC field is left as-is.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr <= '0;
         pc    <= '0;
         valid <= 1'b0;
      end else if (write_en) begin
         if (bubble) begin
            instr <= W'(NOP_INSTR);
            valid <= 1'b0;
         end else begin
            instr <= instr_in;
            pc    <= pc_in;
            valid <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, next-PC select, fetch FSM and IF/ID register.
// Optional IF_PERF_EN adds saturating fetch/stall performance counters.
`default_nettype none

module if_stage
   import if_pkg::*;
#(
   parameter int                  bit_size = 32,
   parameter logic [bit_size-1:0] RESET_PC = '0,
   parameter int                  PC_STEP  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                PCWrite,
   input  logic                IF_IDWrite,
   input  logic                IF_Flush,
   input  logic [1:0]          EX_JumpOP,
   input  logic [bit_size-1:0] EX_BranchAddr,
   input  logic [bit_size-1:0] EX_JumpAddr,
   input  logic [bit_size-1:0] EX_RegAddr,
   output logic                IM_Req,
   output logic [bit_size-1:0] IM_Addr,
   input  logic                IM_Valid,
   input  logic [bit_size-1:0] IM_Data,
   output logic [bit_size-1:0] ID_Instr,
   output logic [bit_size-1:0] ID_PC,
   output logic                ID_Valid,
   output logic                Fetch_Stall
`ifdef IF_PERF_EN
   ,
   output logic [31:0]         Perf_Fetch,
   output logic [31:0]         Perf_Stall
`endif
);

   localparam logic [bit_size-1:0] PC_INC = bit_size'(PC_STEP);

   logic [1:0]          state;
   logic [bit_size-1:0] pc;
   logic [bit_size-1:0] hold_instr;
   logic                avail;
   logic [bit_size-1:0] cur_instr;
   logic                redirect;
   logic                accept;
   logic                stall_next;
   logic [bit_size-1:0] target;

   assign avail      = (state == ST_HOLD) || ((state == ST_FETCH) && IM_Valid);
   assign cur_instr  = (state == ST_HOLD) ? hold_instr : IM_Data;
   assign redirect   = (EX_JumpOP != JOP_NONE);
   assign accept     = IF_IDWrite && PCWrite && !IF_Flush && avail && !redirect;
   assign stall_next = IF_IDWrite && !IF_Flush && !avail;

   assign IM_Req  = (state == ST_FETCH);
   assign IM_Addr = pc;

   always_comb begin
      target = pc;
      case (EX_JumpOP)
         JOP_BR:  target = EX_BranchAddr;
         JOP_J:   target = EX_JumpAddr;
         JOP_JR:  target = EX_RegAddr;
         default: target = pc;
      endcase
   end

   // Redirect outranks a frozen PC; an unanswered request becomes stale (DROP).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc          <= RESET_PC;
         state       <= ST_FETCH;
         hold_instr  <= '0;
         Fetch_Stall <= 1'b0;
      end else begin
         Fetch_Stall <= stall_next;
         if (redirect) begin
            pc    <= target;
            state <= ((state == ST_FETCH) && !IM_Valid) ? ST_DROP : ST_FETCH;
         end else if (accept) begin
            pc    <= pc + PC_INC;
            state <= ST_FETCH;
         end else begin
            case (state)
               ST_FETCH: begin
                  if (IM_Valid) begin
                     state      <= ST_HOLD;
                     hold_instr <= IM_Data;
                  end
               end
               ST_HOLD: state <= ST_HOLD;
               ST_DROP: begin
                  if (IM_Valid) state <= ST_FETCH;
               end
               default: state <= ST_FETCH;
            endcase
         end
      end
   end

   if_id_reg #(
      .W(bit_size)
   ) u_if_id_reg (
      .clk      (clk),
      .rst      (rst),
      .write_en (IF_IDWrite),
      .bubble   (IF_Flush || !avail),
      .instr_in (cur_instr),
      .pc_in    (pc),
      .instr    (ID_Instr),
      .pc       (ID_PC),
      .valid    (ID_Valid)
   );

`ifdef IF_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Perf_Fetch <= '0;
         Perf_Stall <= '0;
      end else begin
         if (accept && (Perf_Fetch != 32'hFFFF_FFFF)) Perf_Fetch <= Perf_Fetch + 32'd1;
         if (stall_next && (Perf_Stall != 32'hFFFF_FFFF)) Perf_Stall <= Perf_Stall + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed tables plus randomized run against a reference model.
`default_nettype none

module tb_if_stage;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          PCWrite, IF_IDWrite, IF_Flush;
   logic [1:0]    EX_JumpOP;
   logic [W-1:0]  EX_BranchAddr, EX_JumpAddr, EX_RegAddr;
   logic          IM_Req;
   logic [W-1:0]  IM_Addr;
   logic          IM_Valid;
   logic [W-1:0]  IM_Data;
   logic [W-1:0]  ID_Instr, ID_PC;
   logic          ID_Valid, Fetch_Stall;
`ifdef IF_PERF_EN
   logic [31:0]   Perf_Fetch, Perf_Stall;
`endif

   always #5 clk = ~clk;

   if_stage #(.bit_size(W), .RESET_PC(32'h0), .PC_STEP(4)) dut (
`ifdef IF_PERF_EN
      .Perf_Fetch    (Perf_Fetch),
      .Perf_Stall    (Perf_Stall),
`endif
      .clk           (clk),
      .rst           (rst),
      .PCWrite       (PCWrite),
      .IF_IDWrite    (IF_IDWrite),
      .IF_Flush      (IF_Flush),
      .EX_JumpOP     (EX_JumpOP),
      .EX_BranchAddr (EX_BranchAddr),
      .EX_JumpAddr   (EX_JumpAddr),
      .EX_RegAddr    (EX_RegAddr),
      .IM_Req        (IM_Req),
      .IM_Addr       (IM_Addr),
      .IM_Valid      (IM_Valid),
      .IM_Data       (IM_Data),
      .ID_Instr      (ID_Instr),
      .ID_PC         (ID_PC),
      .ID_Valid      (ID_Valid),
      .Fetch_Stall   (Fetch_Stall)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        idw, pcw, fl;
      logic [1:0]  jop;
      logic [31:0] br, j, jr;
   } ctrl_t;

   // Instruction memory: one response in flight; data is the word at the address being presented.
   int mem_cnt = 0;
   int mem_lat = 1;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
   endfunction

   // Reference model, in terms of "buffered instruction" and "responses to discard".
   logic [31:0] m_pc;
   logic [31:0] m_buf[$];
   int          m_discard;
   logic [31:0] m_id_instr, m_id_pc;
   logic        m_id_valid, m_stall;
   longint      m_pf, m_ps;

   function automatic ctrl_t go();
      ctrl_t c;
      c.idw = 1'b1; c.pcw = 1'b1; c.fl = 1'b0; c.jop = 2'd0;
      c.br = 32'h0; c.j = 32'h0; c.jr = 32'h0;
      return c;
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_buf.delete(); m_discard = 0;
      m_id_instr = 32'h0; m_id_pc = 32'h0; m_id_valid = 1'b0; m_stall = 1'b0;
      m_pf = 0; m_ps = 0;
   endtask

   task automatic model_step(input ctrl_t c, input logic v, input logic [31:0] d);
      logic        fetching, avail, acc;
      logic [31:0] ins, tgt;
      fetching = (m_buf.size() == 0) && (m_discard == 0);
      avail    = (m_buf.size() != 0) || (fetching && v);
      ins      = (m_buf.size() != 0) ? m_buf[0] : d;
      acc      = c.idw && c.pcw && !c.fl && avail && (c.jop == 2'd0);
      if (c.idw) begin
         if (c.fl || !avail) begin
            m_id_instr = 32'h0; m_id_valid = 1'b0;
         end else begin
            m_id_instr = ins; m_id_pc = m_pc; m_id_valid = 1'b1;
         end
      end
      m_stall = c.idw && !c.fl && !avail;
      if (acc && m_pf < 64'hFFFF_FFFF) m_pf++;
      if (m_stall && m_ps < 64'hFFFF_FFFF) m_ps++;
      if (c.jop != 2'd0) begin
         tgt = (c.jop == 2'd1) ? c.br : (c.jop == 2'd2) ? c.j : c.jr;
         m_discard = (fetching && !v) ? 1 : 0;
         m_buf.delete();
         m_pc = tgt;
      end else if (acc) begin
         m_pc = m_pc + 32'd4;
         m_buf.delete();
      end else begin
         if (fetching && v) m_buf.push_back(d);
         if (m_discard > 0 && v) m_discard--;
      end
   endtask

   task automatic check_model();
      logic        e_req;
      e_req = (m_buf.size() == 0) && (m_discard == 0);
      total++;
      if (ID_Instr !== m_id_instr || ID_PC !== m_id_pc || ID_Valid !== m_id_valid ||
          Fetch_Stall !== m_stall || IM_Req !== e_req || IM_Addr !== m_pc) begin
         bad++;
         $display("FAIL model t=%0t got instr=%h pc=%h v=%b st=%b req=%b addr=%h exp instr=%h pc=%h v=%b st=%b req=%b addr=%h",
                  $time, ID_Instr, ID_PC, ID_Valid, Fetch_Stall, IM_Req, IM_Addr,
                  m_id_instr, m_id_pc, m_id_valid, m_stall, e_req, m_pc);
      end
`ifdef IF_PERF_EN
      total++;
      if (Perf_Fetch !== 32'(m_pf) || Perf_Stall !== 32'(m_ps)) begin
         bad++;
         $display("FAIL perf_model got fetch=%0d stall=%0d exp fetch=%0d stall=%0d",
                  Perf_Fetch, Perf_Stall, m_pf, m_ps);
      end
`endif
   endtask

   task automatic drive_step(input ctrl_t c);
      PCWrite = c.pcw; IF_IDWrite = c.idw; IF_Flush = c.fl; EX_JumpOP = c.jop;
      EX_BranchAddr = c.br; EX_JumpAddr = c.j; EX_RegAddr = c.jr;
      IM_Valid = 1'b0;
      IM_Data  = $urandom;
      if (mem_cnt > 0) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            IM_Valid = 1'b1;
            IM_Data  = inst_of(IM_Addr);
         end
      end
      if (mem_cnt == 0 && IM_Req)
         mem_cnt = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
      model_step(c, IM_Valid, IM_Data);
   endtask

   task automatic tick(input ctrl_t c);
      @(negedge clk);
      check_model();
      drive_step(c);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      PCWrite = 1'b1; IF_IDWrite = 1'b1; IF_Flush = 1'b0; EX_JumpOP = 2'd0;
      EX_BranchAddr = '0; EX_JumpAddr = '0; EX_RegAddr = '0;
      IM_Valid = 1'b0; IM_Data = '0;
      mem_cnt = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_req",   {31'h0, IM_Req}, 32'h1);
      chk("rst_addr",  IM_Addr, 32'h0);
      chk("rst_instr", ID_Instr, 32'h0);
      chk("rst_idpc",  ID_PC, 32'h0);
      chk("rst_idv",   {30'h0, ID_Valid, Fetch_Stall}, 32'h0);
`ifdef IF_PERF_EN
      chk("rst_perf",  Perf_Fetch | Perf_Stall, 32'h0);
`endif
      rst = 1'b1;
      drive_step(go());
   endtask

   typedef struct {
      logic        idv;
      logic [31:0] idpc;
      logic        stall;
      logic [31:0] addr;
   } row_t;

   initial begin
      row_t  tab[6];
      logic  e_st[6];
      logic  e_v[6];
      logic [31:0] e_ad[6];
      ctrl_t c;

      // Zero-wait memory: back-to-back fetch.
      tab[0] = '{1'b0, 32'h00, 1'b1, 32'h00};
      tab[1] = '{1'b1, 32'h00, 1'b0, 32'h04};
      tab[2] = '{1'b1, 32'h04, 1'b0, 32'h08};
      tab[3] = '{1'b1, 32'h08, 1'b0, 32'h0C};
      tab[4] = '{1'b1, 32'h0C, 1'b0, 32'h10};
      tab[5] = '{1'b1, 32'h10, 1'b0, 32'h14};
      mem_lat = 1;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         tick(go());
         chk($sformatf("t1_v%0d", i),    {31'h0, ID_Valid}, {31'h0, tab[i].idv});
         chk($sformatf("t1_pc%0d", i),   ID_PC, tab[i].idpc);
         chk($sformatf("t1_ins%0d", i),  ID_Instr, tab[i].idv ? inst_of(tab[i].idpc) : 32'h0);
         chk($sformatf("t1_st%0d", i),   {31'h0, Fetch_Stall}, {31'h0, tab[i].stall});
         chk($sformatf("t1_ad%0d", i),   IM_Addr, tab[i].addr);
      end

      // Three-cycle memory: two stall cycles per instruction, stable address.
      e_st = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      e_v  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      e_ad = '{32'h4, 32'h4, 32'h4, 32'h8, 32'h8, 32'h8};
      mem_lat = 3;
      do_reset();
      for (int i = 1; i <= 3; i++) tick(go());
      for (int i = 0; i < 6; i++) begin
         tick(go());
         chk($sformatf("t2_st%0d", i), {31'h0, Fetch_Stall}, {31'h0, e_st[i]});
         chk($sformatf("t2_v%0d", i),  {31'h0, ID_Valid}, {31'h0, e_v[i]});
         chk($sformatf("t2_ad%0d", i), IM_Addr, e_ad[i]);
      end

      // Freeze PC and IF/ID for two cycles with PC at 0x10.
      mem_lat = 1;
      do_reset();
      for (int i = 1; i <= 4; i++) tick(go());
      c = go(); c.pcw = 1'b0; c.idw = 1'b0;
      tick(c);
      tick(c);
      chk("t3_hold_pc",  ID_PC, 32'h0C);
      chk("t3_hold_req", {31'h0, IM_Req}, 32'h0);
      tick(go());
      chk("t3_hold_pc2", ID_PC, 32'h0C);
      tick(go());
      chk("t3_load_pc",  ID_PC, 32'h10);
      chk("t3_load_ins", ID_Instr, inst_of(32'h10));
      chk("t3_next_ad",  IM_Addr, 32'h14);

      // Register jump with flush while a request is outstanding.
      mem_lat = 3;
      do_reset();
      c = go(); c.fl = 1'b1; c.jop = 2'b11; c.jr = 32'h400;
      tick(c);
      tick(go());
      chk("t4_req",  {31'h0, IM_Req}, 32'h0);
      chk("t4_addr", IM_Addr, 32'h400);
      chk("t4_bub",  {31'h0, ID_Valid}, 32'h0);
      for (int i = 3; i <= 7; i++) begin
         tick(go());
         chk($sformatf("t4_nov%0d", i), {31'h0, ID_Valid}, 32'h0);
      end
      tick(go());
      chk("t4_pc",  ID_PC, 32'h400);
      chk("t4_ins", ID_Instr, inst_of(32'h400));

      // Sequential wrap of the PC.
      mem_lat = 1;
      do_reset();
      c = go(); c.fl = 1'b1; c.jop = 2'b10; c.j = 32'hFFFF_FFFC;
      tick(c);
      tick(go());
      tick(go());
      chk("t5_wrap_ad", IM_Addr, 32'h0);
      chk("t5_wrap_pc", ID_PC, 32'hFFFF_FFFC);

`ifdef IF_PERF_EN
      mem_lat = 1;
      do_reset();
      for (int i = 1; i <= 9; i++) tick(go());
      mem_lat = 4;
      for (int i = 10; i <= 14; i++) tick(go());
      chk("t6_fetch", Perf_Fetch, 32'd10);
      chk("t6_stall", Perf_Stall, 32'd4);
      mem_lat = 1;
      do_reset();
`endif

      // Randomized control and memory latency, with periodic resets.
      mem_lat = 0;
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if (i % 900 == 899) do_reset();
         c.idw = ($urandom_range(0, 7) != 0);
         c.pcw = c.idw ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
         c.fl  = ($urandom_range(0, 9) == 0);
         c.jop = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         c.br  = $urandom & 32'hFFFF_FFFC;
         c.j   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         c.jr  = $urandom & 32'hFFFF_FFFC;
         tick(c);
      end
      @(negedge clk);
      check_model();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
